// File: rtl/axi_stream_header_arbiter.sv
// axi_stream_header_arbiter
// Round-robin sharing of the axi_stream_insert_header header port between
// NUM_SRC requesters. One header is granted per frame. The grant stays
// locked until the snooped output stream accepts the last beat of that frame.
module axi_stream_header_arbiter #(
  parameter int DATA_WD      = 32,
  parameter int DATA_BYTE_WD = DATA_WD / 8,
  parameter int BYTE_CNT_WD  = $clog2(DATA_BYTE_WD),
  parameter int NUM_SRC      = 4,
  parameter int SRC_WD       = $clog2(NUM_SRC),
  parameter int CNT_WD       = 16
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [NUM_SRC-1:0]                s_valid,
  input  logic [NUM_SRC*DATA_WD-1:0]        s_data,
  input  logic [NUM_SRC*DATA_BYTE_WD-1:0]   s_keep,
  input  logic [NUM_SRC*BYTE_CNT_WD-1:0]    s_byte_cnt,
  output logic [NUM_SRC-1:0]                s_ready,
  output logic                              valid_insert,
  output logic [DATA_WD-1:0]                data_insert,
  output logic [DATA_BYTE_WD-1:0]           keep_insert,
  output logic [BYTE_CNT_WD-1:0]            byte_insert_cnt,
  input  logic                              ready_insert,
  input  logic                              mon_valid_out,
  input  logic                              mon_ready_out,
  input  logic                              mon_last_out,
  output logic [SRC_WD-1:0]                 grant_id,
  output logic                              busy,
  output logic [CNT_WD-1:0]                 frame_cnt,
  output logic                              err
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_HDR   = 2'd1,
    ST_FRAME = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_next_state;
  logic [SRC_WD-1:0]   r_rr_ptr;
  logic [SRC_WD-1:0]   r_grant_id;
  logic [CNT_WD-1:0]   r_frame_cnt;
  logic                r_err;

  logic                w_frame_end;
  logic                w_hdr_fire;
  logic                w_drop_err;
  logic                w_grant_load;
  logic [SRC_WD-1:0]   w_pick;

  // First requester after ptr, searching ptr+1, ptr+2, ... modulo NUM_SRC.
  function automatic logic [SRC_WD-1:0] rr_pick(
    input logic [NUM_SRC-1:0] req,
    input logic [SRC_WD-1:0]  ptr
  );
    logic [SRC_WD-1:0] sel;
    logic              found;
    int                idx;
    sel   = ptr;
    found = 1'b0;
    for (int k = 1; k <= NUM_SRC; k++) begin
      idx = (int'(ptr) + k) % NUM_SRC;
      if (!found && req[idx]) begin
        sel   = SRC_WD'(idx);
        found = 1'b1;
      end
    end
    return sel;
  endfunction

  assign w_frame_end  = mon_valid_out & mon_ready_out & mon_last_out;
  assign w_pick       = rr_pick(s_valid, r_rr_ptr);

  // The header payload always follows the current grant, so it is never X.
  assign data_insert     = s_data[r_grant_id*DATA_WD +: DATA_WD];
  assign keep_insert     = s_keep[r_grant_id*DATA_BYTE_WD +: DATA_BYTE_WD];
  assign byte_insert_cnt = s_byte_cnt[r_grant_id*BYTE_CNT_WD +: BYTE_CNT_WD];

  assign grant_id  = r_grant_id;
  assign busy      = (r_state != ST_IDLE);
  assign frame_cnt = r_frame_cnt;
  assign err       = r_err;

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state decode plus the header-port handshake outputs.
  always_comb begin
    w_next_state = r_state;
    valid_insert = 1'b0;
    s_ready      = '0;
    w_hdr_fire   = 1'b0;
    w_drop_err   = 1'b0;
    w_grant_load = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (|s_valid) begin
          w_grant_load = 1'b1;
          w_next_state = ST_HDR;
        end else begin
          w_next_state = ST_IDLE;
        end
      end
      ST_HDR: begin
        valid_insert        = s_valid[r_grant_id];
        s_ready[r_grant_id] = ready_insert;
        if (s_valid[r_grant_id] && ready_insert) begin
          w_hdr_fire   = 1'b1;
          w_next_state = ST_FRAME;
        end else if (!s_valid[r_grant_id]) begin
          // Granted source withdrew its header: flag it but keep the grant.
          w_drop_err   = 1'b1;
          w_next_state = ST_HDR;
        end else begin
          w_next_state = ST_HDR;
        end
      end
      ST_FRAME: begin
        if (w_frame_end) begin
          w_next_state = ST_IDLE;
        end else begin
          w_next_state = ST_FRAME;
        end
      end
      default: begin
        w_next_state = ST_IDLE;
      end
    endcase
  end

  // Grant index and round-robin pointer; pointer moves only once a header is taken.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_grant_id <= {SRC_WD{1'b0}};
      r_rr_ptr   <= SRC_WD'(NUM_SRC - 1);
    end else begin
      if (w_grant_load) begin
        r_grant_id <= w_pick;
      end
      if (w_hdr_fire) begin
        r_rr_ptr <= r_grant_id;
      end
    end
  end

  // Completed-frame counter, wraps naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_frame_cnt <= {CNT_WD{1'b0}};
    end else if ((r_state == ST_FRAME) && w_frame_end) begin
      r_frame_cnt <= r_frame_cnt + {{(CNT_WD-1){1'b0}}, 1'b1};
    end
  end

  // Sticky error: stray frame end outside FRAME, or header withdrawn in HDR.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err <= 1'b0;
    end else if (w_drop_err || (w_frame_end && (r_state != ST_FRAME))) begin
      r_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_axi_stream_header_arbiter.sv
// Directed self-checking bench for axi_stream_header_arbiter.
module tb_axi_stream_header_arbiter;

  localparam int DATA_WD      = 32;
  localparam int DATA_BYTE_WD = 4;
  localparam int BYTE_CNT_WD  = 2;
  localparam int NUM_SRC      = 4;
  localparam int SRC_WD       = 2;
  localparam int CNT_WD       = 16;

  logic                            clk = 1'b0;
  logic                            rst;
  logic [NUM_SRC-1:0]              s_valid;
  logic [NUM_SRC*DATA_WD-1:0]      s_data;
  logic [NUM_SRC*DATA_BYTE_WD-1:0] s_keep;
  logic [NUM_SRC*BYTE_CNT_WD-1:0]  s_byte_cnt;
  logic [NUM_SRC-1:0]              s_ready;
  logic                            valid_insert;
  logic [DATA_WD-1:0]              data_insert;
  logic [DATA_BYTE_WD-1:0]         keep_insert;
  logic [BYTE_CNT_WD-1:0]          byte_insert_cnt;
  logic                            ready_insert;
  logic                            mon_valid_out;
  logic                            mon_ready_out;
  logic                            mon_last_out;
  logic [SRC_WD-1:0]               grant_id;
  logic                            busy;
  logic [CNT_WD-1:0]               frame_cnt;
  logic                            err;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] t_data [NUM_SRC];
  logic [3:0]  t_keep [NUM_SRC];
  logic [1:0]  t_cnt  [NUM_SRC];

  always #5 clk = ~clk;

  axi_stream_header_arbiter #(
    .DATA_WD(DATA_WD), .DATA_BYTE_WD(DATA_BYTE_WD), .BYTE_CNT_WD(BYTE_CNT_WD),
    .NUM_SRC(NUM_SRC), .SRC_WD(SRC_WD), .CNT_WD(CNT_WD)
  ) dut (
    .clk(clk), .rst(rst),
    .s_valid(s_valid), .s_data(s_data), .s_keep(s_keep), .s_byte_cnt(s_byte_cnt),
    .s_ready(s_ready),
    .valid_insert(valid_insert), .data_insert(data_insert), .keep_insert(keep_insert),
    .byte_insert_cnt(byte_insert_cnt), .ready_insert(ready_insert),
    .mon_valid_out(mon_valid_out), .mon_ready_out(mon_ready_out), .mon_last_out(mon_last_out),
    .grant_id(grant_id), .busy(busy), .frame_cnt(frame_cnt), .err(err)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic settle;
    #1;
  endtask

  task automatic do_reset;
    rst           = 1'b1;
    s_valid       = '0;
    ready_insert  = 1'b0;
    mon_valid_out = 1'b0;
    mon_ready_out = 1'b0;
    mon_last_out  = 1'b0;
    tick;
    tick;
    rst = 1'b0;
    settle;
  endtask

  // Drive 'beats' accepted output beats, last one flagged.
  task automatic end_frame(input int beats);
    for (int b = 0; b < beats; b++) begin
      mon_valid_out = 1'b1;
      mon_ready_out = 1'b1;
      mon_last_out  = (b == beats - 1);
      tick;
    end
    mon_valid_out = 1'b0;
    mon_ready_out = 1'b0;
    mon_last_out  = 1'b0;
    settle;
  endtask

  // From IDLE with requests held and ready_insert=1: expect grant g, run a frame.
  task automatic run_frame(input int g, input int beats);
    tick;
    settle;
    chk("hdr_grant", 32'(grant_id), 32'(g));
    chk("hdr_valid", 32'(valid_insert), 32'd1);
    chk("hdr_sready", 32'(s_ready), 32'(1 << g));
    chk("hdr_data", data_insert, t_data[g]);
    chk("hdr_keep", 32'(keep_insert), 32'(t_keep[g]));
    chk("hdr_bcnt", 32'(byte_insert_cnt), 32'(t_cnt[g]));
    tick;
    settle;
    chk("frm_valid", 32'(valid_insert), 32'd0);
    chk("frm_sready", 32'(s_ready), 32'd0);
    chk("frm_busy", 32'(busy), 32'd1);
    end_frame(beats);
    chk("end_busy", 32'(busy), 32'd0);
  endtask

  initial begin
    t_data[0] = 32'h55555555; t_keep[0] = 4'b0011; t_cnt[0] = 2'd2;
    t_data[1] = 32'h11112222; t_keep[1] = 4'b1111; t_cnt[1] = 2'd3;
    t_data[2] = 32'hA5A5C3C3; t_keep[2] = 4'b0111; t_cnt[2] = 2'd1;
    t_data[3] = 32'hDEADBEEF; t_keep[3] = 4'b1100; t_cnt[3] = 2'd0;
    for (int i = 0; i < NUM_SRC; i++) begin
      s_data[i*DATA_WD +: DATA_WD]              = t_data[i];
      s_keep[i*DATA_BYTE_WD +: DATA_BYTE_WD]    = t_keep[i];
      s_byte_cnt[i*BYTE_CNT_WD +: BYTE_CNT_WD]  = t_cnt[i];
    end

    // Reset state and single source 0.
    do_reset;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_grant", 32'(grant_id), 32'd0);
    chk("rst_cnt", 32'(frame_cnt), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_valid", 32'(valid_insert), 32'd0);
    s_valid = 4'b0001;
    ready_insert = 1'b1;
    settle;
    chk("idle_sready", 32'(s_ready), 32'd0);
    chk("idle_valid", 32'(valid_insert), 32'd0);
    tick;
    settle;
    chk("t1_valid", 32'(valid_insert), 32'd1);
    chk("t1_sready", 32'(s_ready), 32'h1);
    chk("t1_data", data_insert, 32'h55555555);
    chk("t1_keep", 32'(keep_insert), 32'h3);
    tick;
    s_valid = 4'b0000;
    settle;
    chk("t1_frm_valid", 32'(valid_insert), 32'd0);
    chk("t1_frm_sready", 32'(s_ready), 32'd0);
    chk("t1_frm_busy", 32'(busy), 32'd1);
    tick;
    tick;
    end_frame(1);
    chk("t1_cnt", 32'(frame_cnt), 32'd1);
    chk("t1_busy", 32'(busy), 32'd0);
    chk("t1_err", 32'(err), 32'd0);

    // Sources 1 and 3 alternate.
    do_reset;
    s_valid = 4'b1010;
    ready_insert = 1'b1;
    settle;
    run_frame(1, 2);
    run_frame(3, 2);
    run_frame(1, 2);
    run_frame(3, 2);
    chk("t2_cnt", 32'(frame_cnt), 32'd4);
    chk("t2_err", 32'(err), 32'd0);

    // All four request: 0,1,2,3,0.
    do_reset;
    s_valid = 4'b1111;
    ready_insert = 1'b1;
    settle;
    run_frame(0, 1);
    run_frame(1, 1);
    run_frame(2, 1);
    run_frame(3, 1);
    run_frame(0, 1);
    chk("t3_cnt", 32'(frame_cnt), 32'd5);
    chk("t3_err", 32'(err), 32'd0);

    // Back-pressure in HDR from ready_insert.
    do_reset;
    s_valid = 4'b0100;
    ready_insert = 1'b0;
    settle;
    tick;
    settle;
    for (int c = 0; c < 5; c++) begin
      chk("t4_valid", 32'(valid_insert), 32'd1);
      chk("t4_data", data_insert, t_data[2]);
      chk("t4_sready", 32'(s_ready), 32'd0);
      chk("t4_grant", 32'(grant_id), 32'd2);
      tick;
      settle;
    end
    ready_insert = 1'b1;
    settle;
    chk("t4_sready_hs", 32'(s_ready), 32'h4);
    tick;
    settle;
    chk("t4_frm_valid", 32'(valid_insert), 32'd0);
    chk("t4_frm_busy", 32'(busy), 32'd1);
    s_valid = 4'b0000;
    end_frame(1);
    chk("t4_cnt", 32'(frame_cnt), 32'd1);
    chk("t4_err", 32'(err), 32'd0);

    // Stray frame end while IDLE.
    end_frame(1);
    chk("t5_err", 32'(err), 32'd1);
    chk("t5_cnt", 32'(frame_cnt), 32'd1);
    chk("t5_busy", 32'(busy), 32'd0);
    tick;
    settle;
    chk("t5_err_sticky", 32'(err), 32'd1);

    // Reset mid-frame with grant 2.
    do_reset;
    s_valid = 4'b0100;
    ready_insert = 1'b1;
    settle;
    run_frame(2, 1);
    tick;
    settle;
    tick;
    settle;
    chk("t6_frm_busy", 32'(busy), 32'd1);
    chk("t6_frm_grant", 32'(grant_id), 32'd2);
    s_valid = 4'b0101;
    rst = 1'b1;
    tick;
    settle;
    chk("t6_rst_busy", 32'(busy), 32'd0);
    chk("t6_rst_cnt", 32'(frame_cnt), 32'd0);
    chk("t6_rst_grant", 32'(grant_id), 32'd0);
    chk("t6_rst_valid", 32'(valid_insert), 32'd0);
    rst = 1'b0;
    settle;
    tick;
    settle;
    chk("t6_grant", 32'(grant_id), 32'd0);
    chk("t6_valid", 32'(valid_insert), 32'd1);
    chk("t6_sready", 32'(s_ready), 32'h1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
